// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master memory arbiter.
//   state_e     : arbiter FSM states
//   master_id_t : index of a requesting master (0 or 1)
//   widths and default parameter values used by mem_arbiter
package mem_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StResp
  } state_e;

  typedef logic master_id_t;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned WSTRB_W = 4;
  // Wide enough for the largest legal TIMEOUT (255).
  localparam int unsigned CNT_W   = 8;

  localparam int unsigned       DEF_TIMEOUT       = 64;
  localparam logic [DATA_W-1:0] DEF_TIMEOUT_RDATA = 32'h0000_0000;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two masters, the arbiter and a memory controller.
//   m0_* / m1_* : master request (valid/addr/wdata/wstrb) and response (ready/rdata)
//   mem_*       : forwarded request to the memory controller and its completion
//   timeout_err : one-cycle pulse when the memory controller fails to respond
// Modports:
//   slave  : the arbiter's view (accepts master requests, drives memory side)
//   master : the environment's view (masters plus memory controller)
interface mem_arbiter_if;
  import mem_bus_pkg::*;

  logic               m0_valid;
  logic               m0_ready;
  logic [ADDR_W-1:0]  m0_addr;
  logic [DATA_W-1:0]  m0_wdata;
  logic [WSTRB_W-1:0] m0_wstrb;
  logic [DATA_W-1:0]  m0_rdata;

  logic               m1_valid;
  logic               m1_ready;
  logic [ADDR_W-1:0]  m1_addr;
  logic [DATA_W-1:0]  m1_wdata;
  logic [WSTRB_W-1:0] m1_wstrb;
  logic [DATA_W-1:0]  m1_rdata;

  logic               mem_valid;
  logic               mem_ready;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [WSTRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0]  mem_rdata;

  logic               timeout_err;

  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  mem_ready, mem_rdata,
    output m0_ready, m0_rdata, m1_ready, m1_rdata,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output timeout_err
  );

  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output mem_ready, mem_rdata,
    input  m0_ready, m0_rdata, m1_ready, m1_rdata,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  timeout_err
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   req0_i / req1_i : request lines
//   advance_i       : commit the current grant as the new "last granted" master
//   grant_o         : combinational winner for the current requests
// last_grant resets to master 1 so master 0 wins the first tie.
module rr_arbiter2
  import mem_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       advance_i,
  output master_id_t grant_o
);

  master_id_t last_grant_q;

  always_comb begin
    if (req0_i && req1_i) begin
      grant_o = ~last_grant_q;
    end else if (req1_i) begin
      grant_o = 1'b1;
    end else begin
      grant_o = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (advance_i && (req0_i || req1_i)) begin
      last_grant_q <= grant_o;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master to one-memory arbiter with round-robin tie break and response timeout.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : mem_arbiter_if.slave carrying both master ports, the memory port
//                and timeout_err
// One transaction at a time: IDLE picks a winner and issues, GRANT waits for
// mem_ready (or TIMEOUT cycles), RESP pulses the winner's ready. All outputs are
// registered.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned        TIMEOUT       = DEF_TIMEOUT,
  parameter logic [DATA_W-1:0]  TIMEOUT_RDATA = DEF_TIMEOUT_RDATA
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  state_e             state_q, state_d;
  master_id_t         gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [WSTRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic               m0_ready_q, m0_ready_d;
  logic               m1_ready_q, m1_ready_d;
  logic [DATA_W-1:0]  m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]  m1_rdata_q, m1_rdata_d;
  logic               terr_q, terr_d;

  master_id_t         arb_grant;
  logic               arb_advance;
  logic               finish;
  logic [DATA_W-1:0]  resp_rdata;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req0_i    (bus.m0_valid),
    .req1_i    (bus.m1_valid),
    .advance_i (arb_advance),
    .grant_o   (arb_grant)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    m0_ready_d  = 1'b0;
    m1_ready_d  = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    terr_d      = 1'b0;
    arb_advance = 1'b0;
    finish      = 1'b0;
    resp_rdata  = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.m0_valid || bus.m1_valid) begin
          arb_advance = 1'b1;
          gnt_d       = arb_grant;
          mem_valid_d = 1'b1;
          mem_addr_d  = arb_grant ? bus.m1_addr  : bus.m0_addr;
          mem_wdata_d = arb_grant ? bus.m1_wdata : bus.m0_wdata;
          mem_wstrb_d = arb_grant ? bus.m1_wstrb : bus.m0_wstrb;
          cnt_d       = CNT_W'(1);
          // Previous response data is dropped once a new transaction owns the bus.
          m0_rdata_d  = '0;
          m1_rdata_d  = '0;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        // mem_ready takes priority over an expiring count in the same cycle.
        if (bus.mem_ready) begin
          finish     = 1'b1;
          resp_rdata = bus.mem_rdata;
        end else if (cnt_q >= TimeoutCnt) begin
          finish     = 1'b1;
          resp_rdata = TIMEOUT_RDATA;
          terr_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (finish) begin
          mem_valid_d = 1'b0;
          state_d     = StResp;
          if (gnt_q) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = resp_rdata;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = resp_rdata;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      gnt_q       <= 1'b0;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      m0_ready_q  <= 1'b0;
      m1_ready_q  <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      m0_ready_q  <= m0_ready_d;
      m1_ready_q  <= m1_ready_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      terr_q      <= terr_d;
    end
  end

  assign bus.mem_valid   = mem_valid_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_wstrb   = mem_wstrb_q;
  assign bus.m0_ready    = m0_ready_q;
  assign bus.m1_ready    = m1_ready_q;
  assign bus.m0_rdata    = m0_rdata_q;
  assign bus.m1_rdata    = m1_rdata_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a behavioural memory
// controller (mem[i] = i initially, word addressed, configurable latency).
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .TIMEOUT       (8),
    .TIMEOUT_RDATA (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Memory controller model knobs.
  logic [31:0] mem [64];
  int          mem_lat     = 1;
  bit          mem_stuck   = 1'b0;
  bit          force_ready = 1'b0;

  typedef struct {
    bit          got;
    int          issue_at;
    int          mv_cycles;
    bit          stable;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        r0;
    logic        r1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        terr;
    logic        mv_at_ready;
  } txn_t;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [3:0]  ws0;
    logic [3:0]  ws1;
    int          lat;
    bit          stuck;
    logic        exp_id;
    logic [31:0] exp_rd;
    logic        exp_terr;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [11];

  // Memory controller: responds at the negedge so the DUT samples a stable value.
  initial begin
    int cnt;
    int idx;
    cnt = 0;
    for (int i = 0; i < 64; i++) mem[i] = i;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      if (bus.mem_valid) begin
        cnt++;
        if (!mem_stuck && cnt == mem_lat) begin
          idx = int'(bus.mem_addr[7:2]);
          bus.mem_ready = 1'b1;
          if (bus.mem_wstrb == 4'b0000) begin
            bus.mem_rdata = mem[idx];
          end else begin
            for (int b = 0; b < 4; b++) begin
              if (bus.mem_wstrb[b]) mem[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
            end
          end
        end
      end else begin
        cnt = 0;
        bus.mem_ready = force_ready;
        bus.mem_rdata = force_ready ? 32'h5A5A_5A5A : 32'h0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_m(input logic v0, input logic v1, input logic [31:0] a0,
                       input logic [31:0] a1, input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic [3:0] ws0, input logic [3:0] ws1);
    bus.m0_valid = v0;
    bus.m1_valid = v1;
    bus.m0_addr  = a0;
    bus.m1_addr  = a1;
    bus.m0_wdata = wd0;
    bus.m1_wdata = wd1;
    bus.m0_wstrb = ws0;
    bus.m1_wstrb = ws1;
  endtask

  task automatic check_zero(input string name);
    check({name, "_mem_valid"}, 32'(bus.mem_valid), 32'h0);
    check({name, "_mem_addr"}, bus.mem_addr, 32'h0);
    check({name, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    check({name, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'h0);
    check({name, "_m0_ready"}, 32'(bus.m0_ready), 32'h0);
    check({name, "_m1_ready"}, 32'(bus.m1_ready), 32'h0);
    check({name, "_m0_rdata"}, bus.m0_rdata, 32'h0);
    check({name, "_m1_rdata"}, bus.m1_rdata, 32'h0);
    check({name, "_terr"}, 32'(bus.timeout_err), 32'h0);
  endtask

  // Called at the negedge where requests were just applied; returns at the
  // negedge where a ready pulse is visible (or after a bounded wait).
  task automatic collect(input bit drop, output txn_t t);
    t.got = 0; t.issue_at = 0; t.mv_cycles = 0; t.stable = 1;
    t.addr = '0; t.wdata = '0; t.wstrb = '0;
    t.r0 = 0; t.r1 = 0; t.rd0 = '0; t.rd1 = '0; t.terr = 0; t.mv_at_ready = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.m0_ready || bus.m1_ready) begin
        t.got = 1;
        t.r0 = bus.m0_ready;
        t.r1 = bus.m1_ready;
        t.rd0 = bus.m0_rdata;
        t.rd1 = bus.m1_rdata;
        t.terr = bus.timeout_err;
        t.mv_at_ready = bus.mem_valid;
        break;
      end
      if (bus.mem_valid) begin
        t.mv_cycles++;
        if (t.issue_at == 0) begin
          t.issue_at = i;
          t.addr = bus.mem_addr;
          t.wdata = bus.mem_wdata;
          t.wstrb = bus.mem_wstrb;
          if (drop) begin
            bus.m0_valid = 1'b0;
            bus.m1_valid = 1'b0;
          end
        end else if (bus.mem_addr !== t.addr || bus.mem_wdata !== t.wdata ||
                     bus.mem_wstrb !== t.wstrb) begin
          t.stable = 0;
        end
      end
    end
  endtask

  task automatic check_txn(input string name, input txn_t t, input logic exp_id,
                           input logic [31:0] exp_rd, input logic exp_terr, input int exp_cyc,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_wstrb);
    check({name, "_ready_seen"}, 32'(t.got), 32'h1);
    check({name, "_issue_latency"}, 32'(t.issue_at), 32'h1);
    check({name, "_mem_valid_cycles"}, 32'(t.mv_cycles), 32'(exp_cyc));
    check({name, "_mem_stable"}, 32'(t.stable), 32'h1);
    check({name, "_mem_addr"}, t.addr, exp_addr);
    check({name, "_mem_wdata"}, t.wdata, exp_wdata);
    check({name, "_mem_wstrb"}, 32'(t.wstrb), 32'(exp_wstrb));
    check({name, "_mem_valid_in_resp"}, 32'(t.mv_at_ready), 32'h0);
    check({name, "_m0_ready"}, 32'(t.r0), 32'(exp_id == 1'b0));
    check({name, "_m1_ready"}, 32'(t.r1), 32'(exp_id == 1'b1));
    check({name, "_rdata"}, exp_id ? t.rd1 : t.rd0, exp_rd);
    check({name, "_other_rdata"}, exp_id ? t.rd0 : t.rd1, 32'h0);
    check({name, "_timeout_err"}, 32'(t.terr), 32'(exp_terr));
  endtask

  // The cycle after the ready pulse must be a quiet IDLE cycle.
  task automatic post_gap(input string name);
    @(negedge clk);
    check({name, "_gap_m0_ready"}, 32'(bus.m0_ready), 32'h0);
    check({name, "_gap_m1_ready"}, 32'(bus.m1_ready), 32'h0);
    check({name, "_gap_mem_valid"}, 32'(bus.mem_valid), 32'h0);
    check({name, "_gap_terr"}, 32'(bus.timeout_err), 32'h0);
  endtask

  initial begin
    txn_t t;
    int   bad;
    logic id;

    //          v0 v1 a0        a1        wd0 wd1           ws0     ws1   lat stk id rd  terr cyc
    vecs[0]  = '{1, 0, 32'h10, 32'h0,  0, 0,            4'h0, 4'h0, 1, 0, 0, 32'h4,        0, 1};
    vecs[1]  = '{0, 1, 32'h0,  32'h20, 0, 32'hCAFE_F00D, 4'h0, 4'hF, 2, 0, 1, 32'h0,        0, 2};
    vecs[2]  = '{1, 0, 32'h20, 32'h0,  0, 0,            4'h0, 4'h0, 3, 0, 0, 32'hCAFE_F00D, 0, 3};
    vecs[3]  = '{1, 1, 32'h0,  32'h8,  0, 0,            4'h0, 4'h0, 1, 0, 1, 32'h2,        0, 1};
    vecs[4]  = '{1, 0, 32'hC,  32'h0,  0, 0,            4'h0, 4'h0, 1, 0, 0, 32'h3,        0, 1};
    vecs[5]  = '{0, 1, 32'h0,  32'h24, 0, 32'h1122_3344, 4'h0, 4'h5, 1, 0, 1, 32'h0,        0, 1};
    vecs[6]  = '{1, 0, 32'h24, 32'h0,  0, 0,            4'h0, 4'h0, 2, 0, 0, 32'h0022_0044, 0, 2};
    vecs[7]  = '{0, 1, 32'h0,  32'h4,  0, 0,            4'h0, 4'h0, 1, 1, 1, 32'h0,        1, 8};
    vecs[8]  = '{1, 0, 32'h30, 32'h0,  0, 0,            4'h0, 4'h0, 8, 0, 0, 32'hC,        0, 8};
    vecs[9]  = '{0, 1, 32'h0,  32'h3C, 0, 0,            4'h0, 4'h0, 7, 0, 1, 32'hF,        0, 7};
    vecs[10] = '{1, 1, 32'h28, 32'h2C, 0, 0,            4'h0, 4'h0, 1, 0, 0, 32'hA,        0, 1};

    reset = 1'b1;
    set_m(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    // Simultaneous requests after reset: m0 first, then m1 after one IDLE cycle.
    mem_lat = 1;
    set_m(1, 1, 32'h0, 32'h8, 0, 0, 0, 0);
    collect(0, t);
    check_txn("tie_first", t, 0, 32'h0, 0, 1, 32'h0, 32'h0, 4'h0);
    post_gap("tie_first");
    bus.m0_valid = 1'b0;
    collect(0, t);
    check_txn("tie_second", t, 1, 32'h2, 0, 1, 32'h8, 32'h0, 4'h0);
    post_gap("tie_second");

    // Both masters continuously requesting: grants alternate m0, m1, m0, m1.
    for (int k = 0; k < 4; k++) begin
      set_m(1, 1, 32'h40, 32'h44, 0, 0, 0, 0);
      id = (k % 2 == 1);
      collect(0, t);
      check_txn($sformatf("rr%0d", k), t, id, id ? 32'h11 : 32'h10, 0, 1,
                id ? 32'h44 : 32'h40, 32'h0, 4'h0);
      post_gap($sformatf("rr%0d", k));
    end

    for (int i = 0; i < 11; i++) begin
      set_m(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].a1, vecs[i].wd0, vecs[i].wd1,
            vecs[i].ws0, vecs[i].ws1);
      mem_lat   = vecs[i].lat;
      mem_stuck = vecs[i].stuck;
      collect(0, t);
      check_txn($sformatf("vec%0d", i), t, vecs[i].exp_id, vecs[i].exp_rd, vecs[i].exp_terr,
                vecs[i].exp_cyc,
                vecs[i].exp_id ? vecs[i].a1 : vecs[i].a0,
                vecs[i].exp_id ? vecs[i].wd1 : vecs[i].wd0,
                vecs[i].exp_id ? vecs[i].ws1 : vecs[i].ws0);
      post_gap($sformatf("vec%0d", i));
    end
    mem_stuck = 0;

    // Master drops valid during GRANT: transaction still completes.
    mem_lat = 4;
    set_m(1, 0, 32'h14, 32'h0, 0, 0, 0, 0);
    collect(1, t);
    check_txn("drop_valid", t, 0, 32'h5, 0, 4, 32'h14, 32'h0, 4'h0);
    post_gap("drop_valid");

    // Spurious mem_ready outside GRANT is ignored.
    set_m(0, 0, 0, 0, 0, 0, 0, 0);
    force_ready = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.m0_ready || bus.m1_ready || bus.mem_valid || bus.timeout_err) bad++;
    end
    force_ready = 1'b0;
    check("spurious_ready_ignored", 32'(bad), 32'h0);
    mem_lat = 1;
    set_m(0, 1, 32'h0, 32'h8, 0, 0, 0, 0);
    collect(0, t);
    check_txn("after_spurious", t, 1, 32'h2, 0, 1, 32'h8, 32'h0, 4'h0);
    post_gap("after_spurious");

    // Reset while m0 is in GRANT: outputs clear immediately, no late ready.
    mem_stuck = 1;
    set_m(1, 0, 32'h4, 32'h0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("pre_reset_mem_valid", 32'(bus.mem_valid), 32'h1);
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    mem_stuck = 0;
    set_m(0, 0, 0, 0, 0, 0, 0, 0);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.m0_ready || bus.m1_ready || bus.mem_valid || bus.timeout_err) bad++;
    end
    check("no_ready_after_reset", 32'(bad), 32'h0);
    // m0 held the last grant before reset; a fresh tie still goes to m0.
    set_m(1, 1, 32'h18, 32'h1C, 0, 0, 0, 0);
    collect(0, t);
    check_txn("fresh_tie", t, 0, 32'h6, 0, 1, 32'h18, 32'h0, 4'h0);
    post_gap("fresh_tie");
    set_m(0, 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: max cycles to wait for mem_ready per transaction (range 2..255).
REQ-002 Parameter TIMEOUT_RDATA, default 32'h0000_0000: rdata returned to master on timeout.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 m0_valid / m1_valid  in  1  master 0/1 request.
REQ-006 m0_ready / m1_ready  out  1  master 0/1 completion pulse.
REQ-007 m0_addr / m1_addr  in  32  master byte address.
REQ-008 m0_wdata / m1_wdata  in  32  master write data.
REQ-009 m0_wstrb / m1_wstrb  in  4  byte enables; 4'b0000 = read.
REQ-010 m0_rdata / m1_rdata  out  32  read data to master, valid while its ready is high.
REQ-011 mem_valid  out  1  request to downstream memory controller.
REQ-012 mem_ready  in  1  completion from memory controller.
REQ-013 mem_addr / mem_wdata / mem_wstrb  out  32/32/4  forwarded request fields.
REQ-014 mem_rdata  in  32  read data from memory controller.
REQ-015 timeout_err  out  1  one-cycle pulse when a transaction times out.

Function
REQ-016 FSM states IDLE, GRANT, RESP; all outputs registered.
REQ-017 IDLE: if any mX_valid, select winner, latch its addr/wdata/wstrb onto mem_*, assert mem_valid next cycle, go GRANT; else stay.
REQ-018 Arbitration round-robin: if both valid, grant master not granted last; single requester always wins; last_grant resets to 1 (m0 wins first tie).
REQ-019 GRANT: hold mem_valid and mem_* stable; count cycles from 1.
REQ-020 GRANT with mem_ready=1: capture mem_rdata, deassert mem_valid next cycle, go RESP.
REQ-021 GRANT with count reaching TIMEOUT and mem_ready=0: deassert mem_valid, load TIMEOUT_RDATA, pulse timeout_err, go RESP.
REQ-022 mem_ready and timeout in same cycle: mem_ready wins, no timeout_err.
REQ-023 RESP: assert granted master's ready for exactly one cycle with captured rdata; other master's ready stays 0; go IDLE.
REQ-024 mX_rdata of non-granted master holds 0; mX_rdata of granted master holds captured value until next grant.
REQ-025 Latency: master valid sampled in IDLE at cycle N -> mem_valid at N+1; mem_ready at cycle M -> mX_ready at M+1, mem_valid low at M+1.
REQ-026 Minimum gap: one IDLE cycle between transactions; mem_valid never high in RESP or IDLE.
REQ-027 mem_ready while not in GRANT is ignored.
REQ-028 Master dropping valid during GRANT does not abort; transaction completes and ready still pulses.
REQ-029 Masters deassert valid the cycle after their ready; arbiter samples IDLE only, so no double issue.

Reset
REQ-030 reset high asynchronously forces IDLE, last_grant=1, counter=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, m0_ready=m1_ready=0, m0_rdata=m1_rdata=0, timeout_err=0.
REQ-031 Reset mid-transaction abandons it; no ready pulse issued after release; first post-reset request is a fresh arbitration.

Structure
REQ-032 Shared package mem_bus_pkg holds state enum (IDLE/GRANT/RESP), master-id typedef, wstrb width constant, default TIMEOUT and TIMEOUT_RDATA.
REQ-033 One sub-module rr_arbiter2: two request inputs, advance strobe, grant output, owns last_grant register.

Verification
REQ-034 m0 read addr 0x10, memory controller (mem[i]=i) -> mem_valid at N+1, m0_ready pulse one cycle with m0_rdata=0x4; m1_ready stays 0.
REQ-035 m0 and m1 valid same cycle (reads 0x0, 0x8) -> m0 served first (rdata 0x0), then m1 (rdata 0x2), one IDLE gap between.
REQ-036 Both continuously valid 4 transactions -> grant order m0,m1,m0,m1.
REQ-037 m1 write addr 0x20 wdata 0xCAFE_F00D wstrb 4'b1111 -> mem_* match exactly while mem_valid high; later m0 read 0x20 returns 0xCAFE_F00D.
REQ-038 Stub slave never asserts mem_ready, TIMEOUT=8 -> mem_valid high 8 cycles, timeout_err pulse, m0_ready pulse with rdata 0x0.
REQ-039 reset asserted in GRANT -> all outputs 0 immediately (same cycle, async); no ready pulse after release.
